s_machine_core: RTL and testbench
=================================

S_MACHINE_CORE -- requirements
Module: s_machine_core

Interface
REQ-001 Parameter DATA_W, default 16, register/data width; SHALL be >= 16.
REQ-002 Parameter ADDR_W, default 9, data-memory address width; SHALL be >= 9.
REQ-003 Parameter PC_W, default 8, program-counter width; SHALL be >= 8.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  core may accept instructions when high.
REQ-007 inst  input  16  instruction; [15:12] opcode.
REQ-008 inst_valid  input  1  inst holds a valid instruction.
REQ-009 inst_ready  output  1  core accepts inst this cycle.
REQ-010 pc  output  PC_W  address of the next instruction.
REQ-011 mem_req  output  1  memory transaction pending.
REQ-012 mem_we  output  1  1 = store, 0 = load.
REQ-013 mem_addr  output  ADDR_W  memory address, zero-extended from inst[8:0].
REQ-014 mem_wdata  output  DATA_W  store data.
REQ-015 mem_rdata  input  DATA_W  load data, valid when mem_ack is high.
REQ-016 mem_ack  input  1  completes the pending transaction.
REQ-017 flags  output  3  {Z,N,C}.
REQ-018 halted  output  1  core is in HALT.

Function
REQ-019 FSM SHALL have states RUN, MEM_WAIT and HALT.
REQ-020 inst_ready SHALL equal (state==RUN && enable && !reset); accept = inst_valid && inst_ready.
REQ-021 Non-memory instructions SHALL retire on the accept edge (latency 1); pc SHALL become pc+1, or the branch target if the branch is taken.
REQ-022 pc SHALL wrap from 2^PC_W-1 to 0.
REQ-023 INC (0010): dst = inst[11] ? B : A; dst += zero-extended inst[7:0]; Z/N from dst; C = carry out of bit DATA_W-1.
REQ-024 ADD (0100) and SUB (0101) SHALL write A. ADD: C = carry out. SUB: C = borrow (A<B unsigned). Z/N from the result.
REQ-025 OR/AND/XOR (0110/0111/1000) SHALL write A and update Z/N; C SHALL be unchanged.
REQ-026 SHR (1001): C=A[0]; A = logical right shift by 1; update Z/N.
REQ-027 MOV (1010): B=A. EXCH (1011): swap A and B. Flags SHALL be unchanged for both.
REQ-028 CMP (1100) SHALL set flags exactly as SUB and leave A unchanged.
REQ-029 SET (1101) / CLR (1110): inst[10:8] SHALL set/clear Z,N,C respectively.
REQ-030 LD (0000), inst[10]=1: reg(inst[11]?B:A) = inst[9] ? imm8<<(DATA_W-8) : zero-extended imm8; no memory access; flags unchanged.
REQ-031 LD with inst[10]=0, and ST (0001): on the accept edge drive mem_req=1, mem_we, mem_addr and mem_wdata (ST: inst[11]?B:A), then enter MEM_WAIT.
REQ-032 In MEM_WAIT, mem_req/mem_we/mem_addr/mem_wdata SHALL hold stable until mem_ack is high.
REQ-033 On the mem_ack edge: LD writes mem_rdata to its register; mem_req drops; pc increments; state returns to RUN.
REQ-034 mem_ack outside MEM_WAIT SHALL be ignored. enable SHALL NOT affect MEM_WAIT.
REQ-035 BR (0011), mask = inst[10:8]:
- inst[11]=0: taken if mask==000 or any masked flag is 1.
- inst[11]=1: taken if any masked flag is 0; mask 000 acts as a NOP.
- Target = zero-extended inst[7:0].
REQ-036 HALT (1111) SHALL enter HALT with pc+1; only reset SHALL leave HALT.
REQ-037 An accepted instruction with enable low SHALL NOT occur; when no instruction is accepted, all state SHALL hold.

Reset
REQ-038 When reset is high at an edge: A=B=0, pc=0, flags=000, state=RUN, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
REQ-039 Reset SHALL dominate all other inputs, including during MEM_WAIT; a pending transaction is abandoned.

Structure
REQ-040 Package s_machine_pkg SHALL hold the opcode constants, the FSM state enum and the flag bit indices.
REQ-041 Sub-module s_machine_alu (combinational, parametrised by DATA_W) SHALL compute the result, Z, N and C for INC/ADD/SUB/CMP/logic/SHR.

Verification
REQ-042 The bench SHALL cover the following directed scenarios:
- LD A #0xFF; INC A #1 -> A=0x0100, Z=0, N=0, C=0; pc=2.
- LD A hi #0x80; LD B hi #0x80; ADD (DATA_W=16) -> A=0, Z=1, C=1.
- LD A #3; LD B #5; CMP -> A=3, N=1, C=1; then BR 0 001 #0x20 -> pc=0x20.
- ST A addr 0x1A5 with mem_ack delayed 3 cycles -> mem_req high for 4 cycles, mem_addr=0x1A5 stable, inst_ready=0, pc advances once.
- LD B addr 0x010, reset asserted in MEM_WAIT -> next cycle mem_req=0, pc=0, B=0.
- HALT at pc=7 -> halted=1, pc=8, inst_ready=0 for 10 cycles despite inst_valid.

Source files
------------

// File: rtl/s_machine_pkg.sv
// Shared definitions for the s_machine core: opcodes, FSM states, flag indices
// and the branch-condition helper.
package s_machine_pkg;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_BR   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_MOV  = 4'hA;
    localparam logic [3:0] OP_EXCH = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_SET  = 4'hD;
    localparam logic [3:0] OP_CLR  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Flag vector layout is {Z,N,C}
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_OR,
        ALU_AND,
        ALU_XOR,
        ALU_SHR
    } alu_op_t;

    // on_clear=0: taken on empty mask or any masked flag set; on_clear=1: any masked flag clear
    function automatic logic br_taken(input logic on_clear, input logic [2:0] mask,
                                      input logic [2:0] flag_vec);
        if (!on_clear) begin
            return (mask == 3'b000) || ((mask & flag_vec) != 3'b000);
        end
        return (mask & ~flag_vec) != 3'b000;
    endfunction

endpackage

// File: rtl/s_machine_alu.sv
// Combinational ALU for the s_machine core: arithmetic, logic and shift results
// with Z/N/C; logic operations pass the incoming carry through.
module s_machine_alu
    import s_machine_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    input  logic              c_in,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              n,
    output logic              c
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum    = {1'b0, opa} + {1'b0, opb};
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
        case (op)
            ALU_ADD: ;
            ALU_SUB: begin
                result = opa - opb;
                c      = (opa < opb);
            end
            ALU_OR: begin
                result = opa | opb;
                c      = c_in;
            end
            ALU_AND: begin
                result = opa & opb;
                c      = c_in;
            end
            ALU_XOR: begin
                result = opa ^ opb;
                c      = c_in;
            end
            ALU_SHR: begin
                result = {1'b0, opa[DATA_W-1:1]};
                c      = opa[0];
            end
            default: ;
        endcase
        z = (result == '0);
        n = result[DATA_W-1];
    end

endmodule

// File: rtl/s_machine_core.sv
// Accumulator-style core with registers A/B, a single-outstanding memory port and
// a RUN / MEM_WAIT / HALT controller.
module s_machine_core
    import s_machine_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [15:0]       inst,
    input  logic              inst_valid,
    output logic              inst_ready,
    output logic [PC_W-1:0]   pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [2:0]        flags,
    output logic              halted
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [2:0]          flags_q, flags_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                ld_dst_q, ld_dst_d;

    logic [3:0]          opcode;
    logic [7:0]          imm8;
    logic                sel_b;
    logic                accept;
    logic [DATA_W-1:0]   ld_imm;
    logic [PC_W-1:0]     pc_inc;

    alu_op_t             alu_op;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_z;
    logic                alu_n;
    logic                alu_c;
    logic [2:0]          alu_flags;

    assign opcode     = inst[15:12];
    assign imm8       = inst[7:0];
    assign sel_b      = inst[11];
    assign inst_ready = (state_q == ST_RUN) && enable && !reset;
    assign accept     = inst_valid && inst_ready;
    assign pc_inc     = pc_q + PC_W'(1);
    assign ld_imm     = inst[9] ? (DATA_W'(imm8) << (DATA_W - 8)) : DATA_W'(imm8);

    assign pc         = pc_q;
    assign flags      = flags_q;
    assign halted     = (state_q == ST_HALT);
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    // INC works on the selected register with the immediate; everything else is A op B
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = a_q;
        alu_b  = b_q;
        case (opcode)
            OP_INC: begin
                alu_a = sel_b ? b_q : a_q;
                alu_b = DATA_W'(imm8);
            end
            OP_SUB, OP_CMP: alu_op = ALU_SUB;
            OP_OR:          alu_op = ALU_OR;
            OP_AND:         alu_op = ALU_AND;
            OP_XOR:         alu_op = ALU_XOR;
            OP_SHR:         alu_op = ALU_SHR;
            default: ;
        endcase
    end

    s_machine_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op    (alu_op),
        .opa   (alu_a),
        .opb   (alu_b),
        .c_in  (flags_q[FLAG_C]),
        .result(alu_result),
        .z     (alu_z),
        .n     (alu_n),
        .c     (alu_c)
    );

    always_comb begin
        alu_flags         = 3'b000;
        alu_flags[FLAG_Z] = alu_z;
        alu_flags[FLAG_N] = alu_n;
        alu_flags[FLAG_C] = alu_c;
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        pc_d        = pc_q;
        flags_d     = flags_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ld_dst_d    = ld_dst_q;

        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    pc_d = pc_inc;
                    case (opcode)
                        OP_LD: begin
                            if (inst[10]) begin
                                if (sel_b) b_d = ld_imm;
                                else       a_d = ld_imm;
                            end else begin
                                // pc only advances once the load completes
                                pc_d        = pc_q;
                                mem_req_d   = 1'b1;
                                mem_we_d    = 1'b0;
                                mem_addr_d  = ADDR_W'(inst[8:0]);
                                mem_wdata_d = '0;
                                ld_dst_d    = sel_b;
                                state_d     = ST_MEM_WAIT;
                            end
                        end
                        OP_ST: begin
                            pc_d        = pc_q;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = ADDR_W'(inst[8:0]);
                            mem_wdata_d = sel_b ? b_q : a_q;
                            state_d     = ST_MEM_WAIT;
                        end
                        OP_INC: begin
                            if (sel_b) b_d = alu_result;
                            else       a_d = alu_result;
                            flags_d = alu_flags;
                        end
                        OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_SHR: begin
                            a_d     = alu_result;
                            flags_d = alu_flags;
                        end
                        OP_CMP:  flags_d = alu_flags;
                        OP_MOV:  b_d = a_q;
                        OP_EXCH: begin
                            a_d = b_q;
                            b_d = a_q;
                        end
                        OP_SET: flags_d = flags_q | inst[10:8];
                        OP_CLR: flags_d = flags_q & ~inst[10:8];
                        OP_BR: begin
                            if (br_taken(sel_b, inst[10:8], flags_q)) begin
                                pc_d = PC_W'(imm8);
                            end
                        end
                        OP_HALT: state_d = ST_HALT;
                        default: ;
                    endcase
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        if (ld_dst_q) b_d = mem_rdata;
                        else          a_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    pc_d      = pc_inc;
                    state_d   = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            a_q         <= '0;
            b_q         <= '0;
            pc_q        <= '0;
            flags_q     <= 3'b000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ld_dst_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            pc_q        <= pc_d;
            flags_q     <= flags_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ld_dst_q    <= ld_dst_d;
        end
    end

endmodule

// File: tb/tb_s_machine_core.sv
// Self-checking bench for s_machine_core: directed scenarios followed by a random
// instruction stream checked against an instruction-level reference model.
module tb_s_machine_core;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;
    localparam int PC_W   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [15:0]       inst;
    logic              inst_valid;
    logic              inst_ready;
    logic [PC_W-1:0]   pc;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [2:0]        flags;
    logic              halted;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: registers, pc, flags, halt
    logic [15:0] mA;
    logic [15:0] mB;
    logic [7:0]  mPc;
    logic        mZ;
    logic        mN;
    logic        mC;
    logic        mHalt;

    s_machine_core #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .PC_W  (PC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .inst      (inst),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .pc        (pc),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .flags     (flags),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, " pc"}, 32'(pc), 32'(mPc));
        checkOutput({tag, " flags"}, 32'(flags), 32'({mZ, mN, mC}));
        checkOutput({tag, " halted"}, 32'(halted), 32'(mHalt));
    endtask

    task automatic modelReset();
        mA = 16'h0; mB = 16'h0; mPc = 8'h0;
        mZ = 1'b0; mN = 1'b0; mC = 1'b0; mHalt = 1'b0;
    endtask

    task automatic setZN(input logic [15:0] r);
        mZ = (r == 16'h0);
        mN = r[15];
    endtask

    // Instruction-level semantics for everything that does not touch memory
    task automatic modelExec(input logic [15:0] ins);
        logic [16:0] wide;
        logic [15:0] r;
        logic [15:0] v;
        logic [2:0]  m;
        logic [2:0]  fl;
        logic        taken;
        m  = ins[10:8];
        fl = {mZ, mN, mC};
        mPc = mPc + 8'd1;
        case (ins[15:12])
            4'h0: begin
                v = ins[9] ? {ins[7:0], 8'h00} : {8'h00, ins[7:0]};
                if (ins[11]) mB = v; else mA = v;
            end
            4'h2: begin
                wide = {1'b0, (ins[11] ? mB : mA)} + {9'h0, ins[7:0]};
                r = wide[15:0];
                mC = wide[16];
                setZN(r);
                if (ins[11]) mB = r; else mA = r;
            end
            4'h3: begin
                if (!ins[11]) taken = (m == 3'b000) || ((m & fl) != 3'b000);
                else          taken = (m & ~fl) != 3'b000;
                if (taken) mPc = ins[7:0];
            end
            4'h4: begin
                wide = {1'b0, mA} + {1'b0, mB};
                mC = wide[16]; mA = wide[15:0]; setZN(mA);
            end
            4'h5: begin
                mC = (mA < mB); mA = mA - mB; setZN(mA);
            end
            4'h6: begin mA = mA | mB; setZN(mA); end
            4'h7: begin mA = mA & mB; setZN(mA); end
            4'h8: begin mA = mA ^ mB; setZN(mA); end
            4'h9: begin mC = mA[0]; mA = mA >> 1; setZN(mA); end
            4'hA: mB = mA;
            4'hB: begin r = mA; mA = mB; mB = r; end
            4'hC: begin mC = (mA < mB); r = mA - mB; setZN(r); end
            4'hD: begin mZ = mZ | m[2]; mN = mN | m[1]; mC = mC | m[0]; end
            4'hE: begin mZ = mZ & ~m[2]; mN = mN & ~m[1]; mC = mC & ~m[0]; end
            default: mHalt = 1'b1;
        endcase
    endtask

    task automatic applyStimulus(input logic [15:0] ins, input string tag);
        inst = ins; inst_valid = 1'b1; enable = 1'b1;
        #1;
        checkOutput({tag, " ready"}, 32'(inst_ready), 32'd1);
        @(posedge clk); #1;
        inst_valid = 1'b0;
        modelExec(ins);
        checkState(tag);
    endtask

    // Memory instruction: ack arrives after 'delay' wait cycles
    task automatic execMem(input logic [15:0] ins, input int delay, input logic [15:0] rdata,
                           input string tag);
        logic        isSt;
        int          highCount;
        logic [15:0] expW;
        isSt = (ins[15:12] == 4'h1);
        expW = ins[11] ? mB : mA;
        inst = ins; inst_valid = 1'b1; enable = 1'b1;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        highCount = mem_req ? 1 : 0;
        checkOutput({tag, " we"}, 32'(mem_we), 32'(isSt));
        checkOutput({tag, " addr"}, 32'(mem_addr), 32'(ins[8:0]));
        if (isSt) checkOutput({tag, " wdata"}, 32'(mem_wdata), 32'(expW));
        checkOutput({tag, " busy ready"}, 32'(inst_ready), 32'd0);
        checkOutput({tag, " pc hold"}, 32'(pc), 32'(mPc));
        for (int i = 0; i < delay; i++) begin
            enable = 1'($urandom_range(0, 1));
            inst_valid = 1'($urandom_range(0, 1));
            mem_ack = 1'b0;
            @(posedge clk); #1;
            if (mem_req) highCount++;
            checkOutput({tag, " addr stable"}, 32'(mem_addr), 32'(ins[8:0]));
            checkOutput({tag, " pc wait"}, 32'(pc), 32'(mPc));
        end
        enable = 1'b1; inst_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (!isSt) begin
            if (ins[11]) mB = rdata; else mA = rdata;
        end
        mPc = mPc + 8'd1;
        checkOutput({tag, " req cycles"}, 32'(highCount), 32'(delay + 1));
        checkOutput({tag, " req drop"}, 32'(mem_req), 32'd0);
        checkState(tag);
    endtask

    // Registers are only visible through store data
    task automatic readRegs(input string tag);
        execMem(16'h1000, 0, 16'h0, {tag, " rdA"});
        execMem(16'h1800, 0, 16'h0, {tag, " rdB"});
    endtask

    // A cycle in which nothing may be accepted; stray acks must be ignored
    task automatic idleCycle();
        if ($urandom_range(0, 1) == 0) begin
            enable = 1'b0; inst_valid = 1'b1;
        end else begin
            enable = 1'b1; inst_valid = 1'b0;
        end
        inst = 16'($urandom);
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        #1;
        if (!enable) checkOutput("idle ready", 32'(inst_ready), 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0; inst_valid = 1'b0; enable = 1'b1;
        checkOutput("idle req", 32'(mem_req), 32'd0);
        checkState("idle");
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        logic [15:0] ins;
        reset = 1'b1; enable = 1'b0; inst_valid = 1'b0; inst = 16'h0;
        mem_ack = 1'b0; mem_rdata = 16'h0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        enable = 1'b1;
        #1;
        checkOutput("reset ready", 32'(inst_ready), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("post-reset ready", 32'(inst_ready), 32'd1);
        checkOutput("reset req", 32'(mem_req), 32'd0);
        checkOutput("reset we", 32'(mem_we), 32'd0);
        checkOutput("reset addr", 32'(mem_addr), 32'd0);
        checkOutput("reset wdata", 32'(mem_wdata), 32'd0);
        checkState("reset");

        // LD A #0xFF; INC A #1
        applyStimulus(16'h04FF, "s1 ld");
        applyStimulus(16'h2001, "s1 inc");
        checkOutput("s1 pc", 32'(pc), 32'd2);
        checkOutput("s1 flags", 32'(flags), 32'b000);
        readRegs("s1");

        // High-byte loads then ADD overflows to zero
        applyStimulus(16'h0680, "s2 ldA");
        applyStimulus(16'h0E80, "s2 ldB");
        applyStimulus(16'h4000, "s2 add");
        checkOutput("s2 flags", 32'(flags), 32'b101);
        readRegs("s2");

        // CMP 3 vs 5 then branch on carry
        applyStimulus(16'h0403, "s3 ldA");
        applyStimulus(16'h0C05, "s3 ldB");
        applyStimulus(16'hC000, "s3 cmp");
        checkOutput("s3 flags", 32'(flags), 32'b011);
        applyStimulus(16'h3120, "s3 br");
        checkOutput("s3 pc", 32'(pc), 32'h20);
        readRegs("s3");

        // Store with a 3-cycle delayed ack
        execMem(16'h11A5, 3, 16'h0, "s4 st");

        // pc wrap at the top of the address space
        applyStimulus(16'h30FF, "wrap br");
        applyStimulus(16'hD000, "wrap nop");
        checkOutput("wrap pc", 32'(pc), 32'd0);

        // Reset abandons a pending load
        applyStimulus(16'h0C5A, "s5 ldB");
        inst = 16'h0810; inst_valid = 1'b1; enable = 1'b1;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        checkOutput("s5 req", 32'(mem_req), 32'd1);
        checkOutput("s5 addr", 32'(mem_addr), 32'h010);
        doReset();
        checkOutput("s5 req after reset", 32'(mem_req), 32'd0);
        checkOutput("s5 pc after reset", 32'(pc), 32'd0);
        checkState("s5");
        readRegs("s5");

        // HALT at pc=7 then hold off further instructions
        doReset();
        for (int i = 0; i < 7; i++) applyStimulus(16'hD000, "s6 nop");
        applyStimulus(16'hF000, "s6 halt");
        checkOutput("s6 pc", 32'(pc), 32'd8);
        checkOutput("s6 halted", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            inst = 16'($urandom); inst_valid = 1'b1; enable = 1'b1;
            #1;
            checkOutput("s6 ready", 32'(inst_ready), 32'd0);
            @(posedge clk); #1;
            checkState("s6 hold");
        end
        inst_valid = 1'b0;
        doReset();
        checkState("s6 reset");

        // Random instruction stream against the reference model
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) < 2) idleCycle();
            ins = 16'($urandom);
            ins[15:12] = 4'($urandom_range(0, 14));
            if ((ins[15:12] == 4'h0 && !ins[10]) || ins[15:12] == 4'h1) begin
                execMem(ins, $urandom_range(0, 3), 16'($urandom), "rnd mem");
            end else begin
                applyStimulus(ins, "rnd");
            end
            if (i % 25 == 24) readRegs("rnd regs");
        end
        readRegs("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
